// File: rtl/tex_arb_pkg.sv
// Shared types and grant helpers for the texture ROM arbiter.
// The helpers work on a MAX_REQ-wide valid vector; unused requester bits must be zero.
package tex_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
    } tex_tag_t;

    // Zero-extended valid bits make a modulo-MAX_REQ search equal to a modulo-N_REQ one.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         last);
        logic [1:0] cand;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = last + 2'(k);
            if (!found && valid[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    function automatic logic [1:0] fixed_pick(input logic [MAX_REQ-1:0] valid);
        fixed_pick = 2'd0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                fixed_pick = 2'(k);
            end else begin
                fixed_pick = fixed_pick;
            end
        end
    endfunction

endpackage

// File: rtl/tex_tag_pipe.sv
// Shift pipe carrying grant tags alongside the ROM read latency.
// Asynchronous clear drops every in-flight tag the moment reset asserts.
module tex_tag_pipe
    import tex_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  tex_tag_t tag_in,
    output tex_tag_t tag_out
);

    tex_tag_t stage_r [DEPTH];

    // Tag shift register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '{v: 1'b0, idx: 2'b00};
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/texture_rom_arbiter.sv
// Arbitrates up to four requesters onto one synchronous texture ROM and routes texels back.
// Build option: TEX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module texture_rom_arbiter
    import tex_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int AW      = 10,
    parameter int DW      = 16,
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                rom_ce,
    output logic                rom_oce,
    output logic                rom_reset,
    output logic [AW-1:0]       rom_ad,
    input  logic [DW-1:0]       rom_dout
);

    logic [MAX_REQ-1:0] valid_ext_s;
    logic               any_valid_s;
    logic [1:0]         grant_idx_s;
    tex_tag_t           tag_in_s;
    tex_tag_t           tag_out_s;

    // Widen the request vector so the pick helpers see zeros above N_REQ.
    always_comb begin
        valid_ext_s              = {MAX_REQ{1'b0}};
        valid_ext_s[N_REQ-1:0]   = req_valid;
        any_valid_s              = |req_valid;
    end

`ifdef TEX_ARB_FIXED_PRIO_EN
    assign grant_idx_s = fixed_pick(valid_ext_s);
`else
    logic [1:0] last_grant_r;

    assign grant_idx_s = rr_pick(valid_ext_s, last_grant_r);

    // Round-robin pointer; reset value makes requester 0 the first winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 2'(N_REQ - 1);
        end else if (any_valid_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Grant decode: one-hot ready, ROM address/enable and the tag for the pipe.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        rom_ce    = 1'b0;
        rom_ad    = {AW{1'b0}};
        tag_in_s  = '{v: 1'b0, idx: 2'b00};
        if (any_valid_s) begin
            rom_ce       = 1'b1;
            tag_in_s.v   = 1'b1;
            tag_in_s.idx = grant_idx_s;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_idx_s == 2'(i)) begin
                    req_ready[i] = 1'b1;
                    rom_ad       = req_addr[i*AW +: AW];
                end else begin
                    req_ready[i] = 1'b0;
                end
            end
        end else begin
            rom_ce = 1'b0;
        end
    end

    tex_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // Route the emerging tag to a one-hot response valid.
    always_comb begin
        rsp_valid = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_out_s.v && (tag_out_s.idx == 2'(i))) begin
                rsp_valid[i] = 1'b1;
            end else begin
                rsp_valid[i] = 1'b0;
            end
        end
    end

    assign rsp_data  = rom_dout;
    assign rom_oce   = 1'b1;
    assign rom_reset = ~reset_n;

endmodule

// File: tb/tb_texture_rom_arbiter.sv
// Directed bench: one arbiter in bypass ROM mode (latency 1) and one in pipeline mode (latency 2).
module tb_texture_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [19:0] req_addr;

    logic [1:0]  ready1, rspv1, ready2, rspv2;
    logic [15:0] data1, data2, dout1, dout2, dreg2;
    logic        ce1, oce1, rrst1, ce2, oce2, rrst2;
    logic [9:0]  ad1, ad2;

    logic [15:0] mem [1024];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  exp_g;
    int          gnt1_cnt;

    always #5 clk = ~clk;

    texture_rom_arbiter #(.N_REQ(2), .AW(10), .DW(16), .ROM_LAT(1)) d1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rspv1), .rsp_data(data1), .rom_ce(ce1),
        .rom_oce(oce1), .rom_reset(rrst1), .rom_ad(ad1), .rom_dout(dout1));

    texture_rom_arbiter #(.N_REQ(2), .AW(10), .DW(16), .ROM_LAT(2)) d2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rsp_valid(rspv2), .rsp_data(data2), .rom_ce(ce2),
        .rom_oce(oce2), .rom_reset(rrst2), .rom_ad(ad2), .rom_dout(dout2));

    // ROM models: bypass read, and read plus output register.
    always @(posedge clk) begin
        if (ce1) dout1 <= mem[ad1];
        if (ce2) dreg2 <= mem[ad2];
        if (oce2) dout2 <= dreg2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7);
        mem[0]  = 16'hAD75;
        mem[2]  = 16'h9492;
        mem[16] = 16'h6B4D;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_addr  = 20'd0;

        // 1: reset values
        repeat (5) @(negedge clk);
        chk("rst_ready", 32'(ready1), 32'h0);
        chk("rst_rspv1", 32'(rspv1), 32'h0);
        chk("rst_rspv2", 32'(rspv2), 32'h0);
        chk("rst_ce", 32'(ce1), 32'h0);
        chk("rst_ad", 32'(ad1), 32'h0);
        chk("rst_romrst", 32'(rrst1), 32'h1);
        chk("rst_oce", 32'(oce1), 32'h1);
        reset_n = 1'b1;
        #1;
        chk("rel_romrst", 32'(rrst1), 32'h0);
        chk("idle_ce", 32'(ce1), 32'h0);
        tick;

        // 2: single request, req0 addr 2
        req_valid = 2'b01;
        req_addr  = {10'd0, 10'd2};
        #1;
        chk("s_ready", 32'(ready1), 32'h1);
        chk("s_ce", 32'(ce1), 32'h1);
        chk("s_ad", 32'(ad1), 32'd2);
        tick;
        chk("s_rspv", 32'(rspv1), 32'h1);
        chk("s_data", 32'(data1), 32'h9492);
        chk("s_rspv2_early", 32'(rspv2), 32'h0);
        req_valid = 2'b00;
        #1;
        chk("s_idle_ready", 32'(ready1), 32'h0);
        tick;
        chk("s_rspv1_gone", 32'(rspv1), 32'h0);
        chk("s_rspv2", 32'(rspv2), 32'h1);
        chk("s_data2", 32'(data2), 32'h9492);

        // 3: both valid; last grant was 0, so requester 1 goes first in round-robin
        req_valid = 2'b11;
        req_addr  = {10'd16, 10'd0};
        for (int k = 0; k < 6; k++) begin
`ifdef TEX_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
            #1;
            chk("rr_ready", 32'(ready1), 32'(exp_g));
            chk("rr_ad", 32'(ad1), (exp_g == 2'b01) ? 32'd0 : 32'd16);
            tick;
            chk("rr_rspv", 32'(rspv1), 32'(exp_g));
            chk("rr_data", 32'(data1), (exp_g == 2'b01) ? 32'hAD75 : 32'h6B4D);
        end
        req_valid = 2'b00;
        tick;

        // 4: latency 2, three back-to-back req1 accepts with changing addresses
        req_valid = 2'b10;
        req_addr  = {10'd16, 10'd0};
        #1;
        chk("l2_ready0", 32'(ready2), 32'h2);
        chk("l2_ad0", 32'(ad2), 32'd16);
        tick;
        chk("l2_rsp_n1", 32'(rspv2), 32'h0);
        req_addr = {10'd2, 10'd0};
        #1;
        chk("l2_ready1", 32'(ready2), 32'h2);
        tick;
        chk("l2_rsp_n2", 32'(rspv2), 32'h2);
        chk("l2_data_n2", 32'(data2), 32'h6B4D);
        req_addr = {10'd0, 10'd0};
        #1;
        chk("l2_ready2", 32'(ready2), 32'h2);
        tick;
        chk("l2_rsp_n3", 32'(rspv2), 32'h2);
        chk("l2_data_n3", 32'(data2), 32'h9492);
        req_valid = 2'b00;
        tick;
        chk("l2_rsp_n4", 32'(rspv2), 32'h2);
        chk("l2_data_n4", 32'(data2), 32'hAD75);
        tick;
        chk("l2_rsp_n5", 32'(rspv2), 32'h0);

        // 5: reset one cycle after a grant drops in-flight responses
        req_valid = 2'b01;
        req_addr  = {10'd0, 10'd2};
        #1;
        chk("mr_ready", 32'(ready2), 32'h1);
        tick;
        chk("mr_rspv1_pre", 32'(rspv1), 32'h1);
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        chk("mr_rspv1_async", 32'(rspv1), 32'h0);
        chk("mr_rspv2_async", 32'(rspv2), 32'h0);
        chk("mr_romrst", 32'(rrst2), 32'h1);
        tick;
        chk("mr_rspv2_drop", 32'(rspv2), 32'h0);
        reset_n   = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mr_first_grant", 32'(ready1), 32'h1);
        chk("mr_first_grant2", 32'(ready2), 32'h1);
        tick;
        chk("mr_rspv1", 32'(rspv1), 32'h1);
        chk("mr_data1", 32'(data1), 32'h9492);

        // 6: four cycles with both valid; count requester 1 grants
        gnt1_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (ready1[1]) gnt1_cnt++;
            tick;
        end
`ifdef TEX_ARB_FIXED_PRIO_EN
        chk("fp_gnt1_cnt", 32'(gnt1_cnt), 32'd0);
`else
        chk("rr_gnt1_cnt", 32'(gnt1_cnt), 32'd2);
`endif
        req_valid = 2'b00;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
